// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with optional hardwired-zero entry 0,
// same-cycle write-to-read bypass, and a post-reset sweep that zeroes every entry.
module reg_file_2r1w #(
  parameter int W        = 8,
  parameter int D        = 4,
  parameter int ZERO_REG = 0
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         write_en,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] data_in,
  input  logic [D-1:0] raddrA,
  input  logic [D-1:0] raddrB,
  output logic [W-1:0] data_outA,
  output logic [W-1:0] data_outB,
  output logic         ready
);

  localparam int DEPTH = 2 ** D;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   clr_ptr_q, clr_ptr_d;
  logic [W-1:0]   mem_q [DEPTH];
  logic           zero_wr;
  logic           wr_fire;
  logic           byp_a, byp_b;

  assign zero_wr = (ZERO_REG != 0) && (waddr == '0);
  assign wr_fire = (state_q == ST_READY) && !reset && write_en && !zero_wr;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == {D{1'b1}}) begin
        state_d = ST_READY;
      end
    end
  end

  // The array itself is never reset; the sweep walks it one entry per cycle.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_fire) begin
        mem_q[waddr] <= data_in;
      end
    end
  end

  assign byp_a = write_en && !reset && (waddr == raddrA);
  assign byp_b = write_en && !reset && (waddr == raddrB);

  always_comb begin
    data_outA = mem_q[raddrA];
    if (state_q == ST_CLEAR) begin
      data_outA = '0;
    end else if ((ZERO_REG != 0) && (raddrA == '0)) begin
      data_outA = '0;
    end else if (byp_a) begin
      data_outA = data_in;
    end
  end

  always_comb begin
    data_outB = mem_q[raddrB];
    if (state_q == ST_CLEAR) begin
      data_outB = '0;
    end else if ((ZERO_REG != 0) && (raddrB == '0)) begin
      data_outB = '0;
    end else if (byp_b) begin
      data_outB = data_in;
    end
  end

  assign ready = (state_q == ST_READY);

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Drives one ZERO_REG=0 and one ZERO_REG=1 instance in lockstep and checks both
// against an array model of the register file.
module tb_reg_file_2r1w;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int DEPTH = 16;

  logic         CLK;
  logic         reset;
  logic         write_en;
  logic [D-1:0] waddr;
  logic [W-1:0] data_in;
  logic [D-1:0] raddrA;
  logic [D-1:0] raddrB;
  logic [W-1:0] outA0, outB0, outA1, outB1;
  logic         ready0, ready1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: contents per instance, plus "how many clean cycles since reset".
  logic [W-1:0] m0 [DEPTH];
  logic [W-1:0] m1 [DEPTH];
  int           clean_cycles;
  bit           m_ready;

  reg_file_2r1w #(.W(W), .D(D), .ZERO_REG(0)) u_dut0 (
    .CLK(CLK), .reset(reset), .write_en(write_en), .waddr(waddr),
    .data_in(data_in), .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(outA0), .data_outB(outB0), .ready(ready0)
  );

  reg_file_2r1w #(.W(W), .D(D), .ZERO_REG(1)) u_dut1 (
    .CLK(CLK), .reset(reset), .write_en(write_en), .waddr(waddr),
    .data_in(data_in), .raddrA(raddrA), .raddrB(raddrB),
    .data_outA(outA1), .data_outB(outB1), .ready(ready1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_read(input bit zr, input logic [D-1:0] a);
    if (!m_ready) return '0;
    if (zr && a == 0) return '0;
    if (write_en && !reset && waddr == a) return data_in;
    return zr ? m1[a] : m0[a];
  endfunction

  task automatic check_outputs();
    chk("ready0", {7'd0, ready0}, {7'd0, m_ready});
    chk("ready1", {7'd0, ready1}, {7'd0, m_ready});
    chk("outA0", outA0, exp_read(1'b0, raddrA));
    chk("outB0", outB0, exp_read(1'b0, raddrB));
    chk("outA1", outA1, exp_read(1'b1, raddrA));
    chk("outB1", outB1, exp_read(1'b1, raddrB));
  endtask

  task automatic model_edge();
    if (reset) begin
      clean_cycles = 0;
      m_ready      = 1'b0;
    end else if (!m_ready) begin
      clean_cycles++;
      if (clean_cycles == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          m0[i] = '0;
          m1[i] = '0;
        end
      end
    end else if (write_en) begin
      m0[waddr] = data_in;
      if (waddr != 0) m1[waddr] = data_in;
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge CLK);
    model_edge();
    #1;
    $display("cyc t=%0t rst=%0b we=%0b wa=%0d din=%h ra=%0d rb=%0d rdy=%0b",
             $time, reset, write_en, waddr, data_in, raddrA, raddrB, ready0);
  endtask

  task automatic count_sweep(input string tag);
    int n;
    n = 0;
    while (!ready0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n[W-1:0], 8'd16);
  endtask

  task automatic do_write(input logic [D-1:0] a, input logic [W-1:0] d);
    write_en = 1'b1; waddr = a; data_in = d;
    tick();
    write_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write_en = 1'b0; waddr = '0; data_in = '0;
    raddrA = '0; raddrB = '0;
    clean_cycles = 0; m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin m0[i] = '0; m1[i] = '0; end
    @(posedge CLK);
    #1;

    // Initial reset and sweep, with a write attempted mid-sweep.
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    write_en = 1'b1; waddr = 4'd3; data_in = 8'h77; raddrA = 4'd3;
    tick();
    write_en = 1'b0;
    while (!ready0 && clean_cycles < 40) tick();
    #1;
    chk("sweep_drop_w3", outA0, 8'h00);

    // Preload entry 5, reset for two cycles, count clear latency.
    do_write(4'd5, 8'hAA);
    raddrA = 4'd5;
    #1;
    chk("preload5", outA0, 8'hAA);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    count_sweep("clear_latency");
    raddrA = 4'd5; raddrB = 4'd3;
    #1;
    chk("entry5_cleared", outA0, 8'h00);
    chk("entry3_cleared", outB0, 8'h00);

    // Dual read.
    do_write(4'd1, 8'h11);
    do_write(4'd2, 8'h22);
    raddrA = 4'd1; raddrB = 4'd2;
    #1;
    chk("dualA", outA0, 8'h11);
    chk("dualB", outB0, 8'h22);
    tick();

    // Bypass on both ports.
    do_write(4'd7, 8'h33);
    write_en = 1'b1; waddr = 4'd7; data_in = 8'h44; raddrA = 4'd7; raddrB = 4'd7;
    #1;
    chk("bypA", outA0, 8'h44);
    chk("bypB", outB1, 8'h44);
    tick();
    write_en = 1'b0;
    #1;
    chk("postA", outA1, 8'h44);
    chk("postB", outB0, 8'h44);

    // Entry 0 write: hardwired zero vs ordinary register.
    write_en = 1'b1; waddr = 4'd0; data_in = 8'hFF; raddrA = 4'd0;
    #1;
    chk("z1_during", outA1, 8'h00);
    chk("z0_during", outA0, 8'hFF);
    tick();
    write_en = 1'b0;
    #1;
    chk("z1_after", outA1, 8'h00);
    chk("z0_after", outA0, 8'hFF);

    // Random traffic with rare resets.
    for (int i = 0; i < 300; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      write_en = $urandom_range(0, 1);
      waddr    = D'($urandom);
      data_in  = W'($urandom);
      raddrA   = ($urandom_range(0, 3) == 0) ? waddr : D'($urandom);
      raddrB   = ($urandom_range(0, 3) == 0) ? waddr : D'($urandom);
      tick();
    end
    reset = 1'b0; write_en = 1'b0;

    // Mid-sweep reset restarts from entry 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_sweep("midsweep_latency");
    for (int i = 0; i < DEPTH; i++) begin
      raddrA = D'(i);
      raddrB = D'(DEPTH - 1 - i);
      #1;
      chk("midsweep_zeroA", outA0, 8'h00);
      chk("midsweep_zeroB", outB1, 8'h00);
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
